// File: rtl/led_scan_driver.sv
// Multiplexed 7-segment LED scan driver.
// A prescaler divides each digit slot into SCAN_DIV clocks. The digit index
// advances once per slot, and a frame is one full pass over all digits.
// New display data is double-buffered. It only reaches the active buffer at a
// frame wrap, so a frame never shows a mix of old and new digits.
// Brightness is PWM: each slot is cut into 16 subslots, and the anode stays
// on for subslots 0..bright.
//
// Load semantics: load is a single-cycle strobe with no back-pressure. Every
// cycle with load = 1 overwrites the pending buffer and sets the pending flag.
// If the strobe lands on the commit cycle, the previously pending data
// commits, and the new data stays pending for the next frame.
module led_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   dat_in,
  input  logic [DIGITS-1:0]     dot_in,
  input  logic [DIGITS-1:0]     en_in,
  input  logic                  blank_lz,
  input  logic [3:0]            bright,
  output logic [7:0]            seg_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame
);

  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW  = $clog2(SCAN_DIV);
  localparam int SUB = SCAN_DIV / 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] SUB_LEN  = CW'(SUB);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   pend_dat, act_dat;
  logic [DIGITS-1:0]     pend_dot, act_dot;
  logic [DIGITS-1:0]     pend_en,  act_en;
  logic                  flag;

  logic                  slot_end;
  logic                  frame_end;
  logic [CW-1:0]         sub;
  logic [3:0]            subslot;
  logic [3:0]            nib;
  logic                  dot;
  logic [6:0]            hex;
  logic [DIGITS-1:0]     supp;
  logic                  lit;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Prescaler and digit index; idx steps on the last clock of each slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= frame_end ? '0 : idx + 1'b1;
    end
  end

  // Frame pulse, high for the first cycle after the index wraps to digit 0.
  always_ff @(posedge clk) begin
    if (rst) frame <= 1'b0;
    else     frame <= frame_end;
  end

  // Double buffer. Pending data moves to active only at a frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_dat <= '0;
      pend_dot <= '0;
      pend_en  <= '0;
      act_dat  <= '0;
      act_dot  <= '0;
      act_en   <= '0;
      flag     <= 1'b0;
    end else begin
      if (frame_end && flag) begin
        act_dat <= pend_dat;
        act_dot <= pend_dot;
        act_en  <= pend_en;
        flag    <= 1'b0;
      end
      if (load) begin
        pend_dat <= dat_in;
        pend_dot <= dot_in;
        pend_en  <= en_in;
        flag     <= 1'b1;
      end
    end
  end

  // Select the current digit and find its PWM subslot.
  always_comb begin
    nib     = act_dat[4*int'(idx) +: 4];
    dot     = act_dot[idx];
    sub     = cnt / SUB_LEN;
    subslot = sub[3:0];
  end

  // Active-low hex decode, bits g..a.
  always_comb begin
    hex = 7'h7F;
    case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
      default: hex = 7'h7F;
    endcase
  end

  // Leading-zero suppression. Walk down from the top digit and keep blanking
  // while every digit so far is zero and undotted. A dot ends the leading run.
  always_comb begin
    logic run;
    supp = '0;
    run  = blank_lz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run     = run && (act_dat[4*i +: 4] == 4'h0) && !act_dot[i];
      supp[i] = run;
    end
  end

  assign lit = (subslot <= bright) && act_en[idx] && !supp[idx];

  // Registered segment and anode outputs, one cycle behind the scan state.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_n <= 8'hFF;
      an_n  <= '1;
    end else if (lit) begin
      seg_n <= {~dot, hex};
      an_n  <= ~(DIGITS'(1) << idx);
    end else begin
      seg_n <= 8'hFF;
      an_n  <= '1;
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Bench for led_scan_driver with DIGITS = 4 and SCAN_DIV = 16.
// The reference model derives the scan position from the number of cycles
// since reset (cnt = t % 16, idx = t / 16 % 4). It keeps the display buffers
// as plain variables, and it decodes hex from a lookup table.
module tb_led_scan_driver;

  localparam int D  = 4;
  localparam int SD = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [4*D-1:0] dat_in;
  logic [D-1:0]  dot_in;
  logic [D-1:0]  en_in;
  logic          blank_lz;
  logic [3:0]    bright;
  logic [7:0]    seg_n;
  logic [D-1:0]  an_n;
  logic          frame;

  int tests = 0;
  int fails = 0;

  led_scan_driver #(.DIGITS(D), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .load(load), .dat_in(dat_in), .dot_in(dot_in),
    .en_in(en_in), .blank_lz(blank_lz), .bright(bright),
    .seg_n(seg_n), .an_n(an_n), .frame(frame)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model state
  logic [6:0]     hex_tab [16];
  int             m_t;
  logic [4*D-1:0] m_pdat, m_adat;
  logic [D-1:0]   m_pdot, m_adot, m_pen, m_aen;
  bit             m_flag;

  logic [7:0]     e_seg;
  logic [D-1:0]   e_an;
  logic           e_frame;

  function automatic bit model_suppressed(int i);
    if (!blank_lz || i == 0) return 1'b0;
    for (int j = i; j < D; j++)
      if (m_adat[4*j +: 4] != 4'h0 || m_adot[j]) return 1'b0;
    return 1'b1;
  endfunction

  // Apply one clock edge and check the outputs against the model.
  task automatic tick();
    int  cnt, idx;
    bit  wrap;
    if (rst) begin
      e_seg = 8'hFF; e_an = '1; e_frame = 1'b0;
    end else begin
      cnt  = m_t % SD;
      idx  = (m_t / SD) % D;
      wrap = (cnt == SD - 1) && (idx == D - 1);
      e_frame = wrap;
      e_seg = 8'hFF; e_an = '1;
      if ((cnt / (SD / 16)) <= int'(bright) && m_aen[idx] && !model_suppressed(idx)) begin
        e_an[idx] = 1'b0;
        e_seg = {~m_adot[idx], hex_tab[m_adat[4*idx +: 4]]};
      end
    end
    @(posedge clk);
    #1;
    tests++;
    assert (an_n === e_an) else begin
      fails++; $error("FAIL an_n t=%0d got %h exp %h", m_t, an_n, e_an);
    end
    tests++;
    assert (seg_n === e_seg) else begin
      fails++; $error("FAIL seg_n t=%0d got %h exp %h", m_t, seg_n, e_seg);
    end
    tests++;
    assert (frame === e_frame) else begin
      fails++; $error("FAIL frame t=%0d got %b exp %b", m_t, frame, e_frame);
    end
    // advance model
    if (rst) begin
      m_t = 0; m_pdat = '0; m_adat = '0; m_pdot = '0; m_adot = '0;
      m_pen = '0; m_aen = '0; m_flag = 1'b0;
    end else begin
      if (wrap && m_flag) begin
        m_adat = m_pdat; m_adot = m_pdot; m_aen = m_pen; m_flag = 1'b0;
      end
      if (load) begin
        m_pdat = dat_in; m_pdot = dot_in; m_pen = en_in; m_flag = 1'b1;
      end
      m_t++;
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(logic [4*D-1:0] d, logic [D-1:0] dt, logic [D-1:0] e);
    dat_in = d; dot_in = dt; en_in = e; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Run until the model's next cycle is the frame-commit cycle (bounded).
  task automatic run_to_commit();
    for (int i = 0; i < SD * D && (m_t % (SD * D)) != SD * D - 1; i++) tick();
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    m_t = 0; m_pdat = '0; m_adat = '0; m_pdot = '0; m_adot = '0;
    m_pen = '0; m_aen = '0; m_flag = 1'b0;
    rst = 1'b1; load = 1'b0; dat_in = '0; dot_in = '0; en_in = '0;
    blank_lz = 1'b0; bright = 4'hF;

    // Reset state
    run(3);
    rst = 1'b0;
    run(5);

    // Basic scan of 1234 at full brightness
    do_load(16'h1234, 4'h0, 4'hF);
    run(200);

    // Tear-free update mid-frame
    run(20);
    do_load(16'h5678, 4'h0, 4'hF);
    run(150);

    // Leading-zero suppression, then a top dot ends the blanked run
    blank_lz = 1'b1;
    do_load(16'h0070, 4'h0, 4'hF);
    run(140);
    do_load(16'h0070, 4'h8, 4'hF);
    run(140);
    blank_lz = 1'b0;

    // Brightness PWM
    bright = 4'd3;
    run(80);
    bright = 4'd0;
    run(80);
    bright = 4'hF;

    // Load collision on the commit cycle
    do_load(16'hABCD, 4'h5, 4'hF);
    run_to_commit();
    do_load(16'hEF01, 4'hA, 4'hF);
    run(140);

    // Reset mid-scan with a load in the same cycle; display stays dark
    run(27);
    rst = 1'b1;
    dat_in = 16'h9999; en_in = 4'hF; load = 1'b1;
    tick();
    load = 1'b0; rst = 1'b0;
    run(100);
    do_load(16'h4321, 4'h2, 4'hB);
    run(140);

    // Randomized loads and live controls
    for (int k = 0; k < 25; k++) begin
      blank_lz = 1'($urandom_range(0, 1));
      bright   = 4'($urandom_range(0, 15));
      do_load(16'($urandom), 4'($urandom), 4'($urandom));
      run($urandom_range(1, 90));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
